wb_axi_bridge: RTL and testbench
================================

WB_AXI_BRIDGE -- requirements
Module: wb_axi_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, meaning the Wishbone base address of the bridge window.
REQ-002 SHALL have parameter ADDR_W, default 12, meaning the AXI-Lite address width; window size is 2^ADDR_W bytes.
REQ-003 SHALL have parameter STRM_OFF, default 'h80, meaning the window offset at or above which accesses are stream accesses.
REQ-004 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of wait cycles per transfer before error; 0 disables the timeout.
REQ-005 Ports (name, direction, width, meaning):
- wb_clk_i, in, 1: the single clock.
- wb_rst_i, in, 1: reset, synchronous, active-high.
- wbs_cyc_i, wbs_stb_i, wbs_we_i, in, 1 each: Wishbone cycle, strobe and write-enable.
- wbs_sel_i, in, 4: byte selects.
- wbs_adr_i, wbs_dat_i, in, 32 each: address and write data.
- wbs_ack_o, wbs_err_o, out, 1 each: Wishbone acknowledge and error.
- wbs_dat_o, out, 32: read data.
REQ-006 AXI-Lite master ports SHALL be:
- Write address: awvalid out, awready in, awaddr out [ADDR_W].
- Write data: wvalid out, wready in, wdata out 32, wstrb out 4.
- Write response: bvalid in, bready out, bresp in 2.
- Read address: arvalid out, arready in, araddr out [ADDR_W].
- Read data: rvalid in, rready out, rdata in 32, rresp in 2.
REQ-007 AXI-Stream ports SHALL be:
- Master: ss_tvalid out, ss_tready in, ss_tdata out 32, ss_tlast out.
- Slave: sm_tvalid in, sm_tready out, sm_tdata in 32, sm_tlast in.

Function
REQ-008 Offset SHALL be computed as off = wbs_adr_i - BASE_ADDR, and a request SHALL be cyc & stb while in IDLE.
REQ-009 A request with off >= 2^ADDR_W SHALL go to ERR without any AXI activity.
REQ-010 The FSM SHALL have the states IDLE, LWR, LB, LRA, LRD, SX, SY, ACK and ERR.
REQ-011 IDLE SHALL branch on each request as follows:
- Write with off < STRM_OFF goes to LWR.
- Read with off < STRM_OFF goes to LRA.
- Write with off >= STRM_OFF goes to SX.
- Read with off >= STRM_OFF goes to SY.
REQ-012 In LWR, awvalid and wvalid SHALL both be asserted on entry; each SHALL drop independently after its own handshake cycle; when both handshakes are complete the FSM SHALL go to LB.
REQ-013 In LWR, awaddr SHALL equal off[ADDR_W-1:0], wdata SHALL equal wbs_dat_i, and wstrb SHALL equal wbs_sel_i.
REQ-014 In LB, bready SHALL be 1; on bvalid the FSM SHALL go to ACK if bresp == 0 and to ERR otherwise.
REQ-015 In LRA, arvalid SHALL be 1 and araddr SHALL equal off[ADDR_W-1:0]; on arready the FSM SHALL go to LRD.
REQ-016 In LRD, rready SHALL be 1; on rvalid the bridge SHALL register rdata into wbs_dat_o, then go to ACK if rresp == 0 and to ERR otherwise.
REQ-017 In SX, ss_tvalid SHALL be 1 and ss_tdata SHALL equal wbs_dat_i; ss_tlast SHALL be 1 iff off == STRM_OFF+4; on ss_tready the FSM SHALL go to ACK.
REQ-018 In SY, sm_tready SHALL be 1; on sm_tvalid the bridge SHALL register sm_tdata into wbs_dat_o.
REQ-019 On the same sm_tvalid handshake in SY, the bridge SHALL register sm_tlast into an internal last_seen flag and go to ACK.
REQ-020 A stream read at off == STRM_OFF+8 SHALL bypass SY and SHALL ACK with wbs_dat_o = {31'b0, last_seen}.
REQ-021 Reading last_seen as in REQ-020 SHALL clear last_seen.
REQ-022 ACK SHALL assert wbs_ack_o for exactly one cycle, then return to IDLE; ERR SHALL do the same with wbs_err_o; ack and err SHALL never be asserted together.
REQ-023 Timeout behaviour:
- A wait counter SHALL clear on leaving IDLE and increment each cycle spent in LWR, LB, LRA, LRD, SX or SY.
- When the counter reaches TIMEOUT (nonzero), all AXI valid and ready outputs SHALL drop in that cycle and the FSM SHALL go to ERR.
REQ-024 If wbs_cyc_i drops mid-transfer, the AXI transfer SHALL still complete; the resulting ack or err SHALL be issued and ignored by the master.
REQ-025 wbs_dat_o SHALL hold its last value except as updated by REQ-016, REQ-018 and REQ-020.
REQ-026 The minimum latency from request to ack SHALL be 3 cycles for AXI-Lite write and 3 for AXI-Lite read (ready high), and 2 for a stream access (ready or valid high).

Reset
REQ-027 On wb_rst_i = 1 at a clock edge, the following SHALL all be forced to 0:
- FSM state to IDLE, wait counter, last_seen, wbs_dat_o.
- wbs_ack_o, wbs_err_o, awvalid, wvalid, bready, arvalid, rready, ss_tvalid, ss_tlast, sm_tready.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer and produce no ack or err.

Verification
REQ-029 Lite write with off 0x10, data 0xA5A5_0001, sel 4'b0011, awready delayed 2 cycles after wready, bresp 0 -> wstrb = 3; one awvalid and one wvalid handshake; wbs_ack_o pulses once.
REQ-030 Lite read with off 0x20, rdata 0x1234_5678, rresp 2 -> wbs_err_o pulses once; wbs_dat_o = 0x1234_5678; wbs_ack_o stays 0.
REQ-031 Stream write to off 0x84 with ss_tready held low for 3 cycles -> ss_tlast = 1 throughout; ss_tvalid is 1 for 4 cycles; ack arrives 1 cycle after the handshake.
REQ-032 Stream read with sm_tlast = 1 and sm_tdata = 7, then read of off 0x88 -> wbs_dat_o = 7, then 1, then 0 on a repeated read.
REQ-033 TIMEOUT = 4 with arready stuck low -> arvalid drops after 4 wait cycles; wbs_err_o pulses; the next access succeeds.
REQ-034 Access at BASE_ADDR + 0x1000, and reset asserted during LB -> immediate err with no AXI valid; after reset, all outputs are 0 and state is IDLE.

Source files
------------

// File: rtl/wb_axi_bridge.sv
// Wishbone slave that forwards window accesses to an AXI-Lite master (low offsets)
// or to a pair of AXI-Stream ports (offsets from STRM_OFF upward).
module wb_axi_bridge #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          ADDR_W    = 12,
   parameter int unsigned STRM_OFF  = 'h80,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic              wbs_err_o,
   output logic [31:0]       wbs_dat_o,
   output logic              awvalid,
   input  logic              awready,
   output logic [ADDR_W-1:0] awaddr,
   output logic              wvalid,
   input  logic              wready,
   output logic [31:0]       wdata,
   output logic [3:0]        wstrb,
   input  logic              bvalid,
   output logic              bready,
   input  logic [1:0]        bresp,
   output logic              arvalid,
   input  logic              arready,
   output logic [ADDR_W-1:0] araddr,
   input  logic              rvalid,
   output logic              rready,
   input  logic [31:0]       rdata,
   input  logic [1:0]        rresp,
   output logic              ss_tvalid,
   input  logic              ss_tready,
   output logic [31:0]       ss_tdata,
   output logic              ss_tlast,
   input  logic              sm_tvalid,
   output logic              sm_tready,
   input  logic [31:0]       sm_tdata,
   input  logic              sm_tlast
);

   localparam int               CNT_W         = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TIMEOUT_VAL   = CNT_W'(TIMEOUT);
   localparam logic [32:0]      WINDOW_SIZE   = 33'd1 << ADDR_W;
   localparam logic [31:0]      STRM_BASE     = 32'(STRM_OFF);
   localparam logic [31:0]      TLAST_OFF     = STRM_BASE + 32'd4;
   localparam logic [31:0]      LAST_FLAG_OFF = STRM_BASE + 32'd8;

   typedef enum logic [3:0] {IDLE, LWR, LB, LRA, LRD, SX, SY, ACK, ERR} BridgeState;

   BridgeState        state, nextState;
   logic [31:0]       off;
   logic              request, inWindow, isStream, isFlagRead, waitState, timeoutHit;
   logic [CNT_W-1:0]  waitCnt;
   logic [ADDR_W-1:0] offReg;
   logic [31:0]       datReg;
   logic [3:0]        selReg;
   logic              tlastReg, awDone, wDone, lastSeen;
   logic              awHs, wHs, bHs, arHs, rHs, ssHs, smHs;

   assign off        = wbs_adr_i - BASE_ADDR;
   assign request    = wbs_cyc_i & wbs_stb_i;
   assign inWindow   = {1'b0, off} < WINDOW_SIZE;
   assign isStream   = off >= STRM_BASE;
   assign isFlagRead = off == LAST_FLAG_OFF;
   assign waitState  = (state == LWR) || (state == LB) || (state == LRA) ||
                       (state == LRD) || (state == SX) || (state == SY);
   assign timeoutHit = (TIMEOUT != 0) && waitState && (waitCnt == TIMEOUT_VAL);

   assign awHs = awvalid & awready;
   assign wHs  = wvalid & wready;
   assign bHs  = bready & bvalid;
   assign arHs = arvalid & arready;
   assign rHs  = rready & rvalid;
   assign ssHs = ss_tvalid & ss_tready;
   assign smHs = sm_tready & sm_tvalid;

   // State register; reset abandons any transfer in flight without a response.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state decode; an expired wait budget overrides every pending handshake.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (request) begin
               if (!inWindow)       nextState = ERR;
               else if (!isStream)  nextState = wbs_we_i ? LWR : LRA;
               else if (wbs_we_i)   nextState = SX;
               else if (isFlagRead) nextState = ACK;
               else                 nextState = SY;
            end
         end
         LWR: begin
            if (timeoutHit)                                  nextState = ERR;
            else if ((awDone || awHs) && (wDone || wHs))     nextState = LB;
         end
         LB: begin
            if (timeoutHit) nextState = ERR;
            else if (bHs)   nextState = (bresp == 2'b00) ? ACK : ERR;
         end
         LRA: begin
            if (timeoutHit) nextState = ERR;
            else if (arHs)  nextState = LRD;
         end
         LRD: begin
            if (timeoutHit) nextState = ERR;
            else if (rHs)   nextState = (rresp == 2'b00) ? ACK : ERR;
         end
         SX: begin
            if (timeoutHit) nextState = ERR;
            else if (ssHs)  nextState = ACK;
         end
         SY: begin
            if (timeoutHit) nextState = ERR;
            else if (smHs)  nextState = ACK;
         end
         ACK:     nextState = IDLE;
         ERR:     nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Bus outputs are decoded from state and the request captured on leaving IDLE.
   always_comb begin
      awvalid   = (state == LWR) && !awDone && !timeoutHit;
      wvalid    = (state == LWR) && !wDone && !timeoutHit;
      bready    = (state == LB) && !timeoutHit;
      arvalid   = (state == LRA) && !timeoutHit;
      rready    = (state == LRD) && !timeoutHit;
      ss_tvalid = (state == SX) && !timeoutHit;
      ss_tlast  = (state == SX) && tlastReg;
      sm_tready = (state == SY) && !timeoutHit;
      awaddr    = offReg;
      araddr    = offReg;
      wdata     = datReg;
      wstrb     = selReg;
      ss_tdata  = datReg;
      wbs_ack_o = (state == ACK);
      wbs_err_o = (state == ERR);
   end

   // Request capture lets the AXI side finish even if the master abandons the cycle.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         waitCnt   <= '0;
         offReg    <= '0;
         datReg    <= '0;
         selReg    <= '0;
         tlastReg  <= 1'b0;
         awDone    <= 1'b0;
         wDone     <= 1'b0;
         lastSeen  <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         if (state == IDLE) begin
            waitCnt <= '0;
            awDone  <= 1'b0;
            wDone   <= 1'b0;
            if (request) begin
               offReg   <= off[ADDR_W-1:0];
               datReg   <= wbs_dat_i;
               selReg   <= wbs_sel_i;
               tlastReg <= (off == TLAST_OFF);
            end
            if (request && !wbs_we_i && inWindow && isFlagRead) begin
               wbs_dat_o <= {31'b0, lastSeen};
               lastSeen  <= 1'b0;
            end
         end else if (waitState) begin
            waitCnt <= waitCnt + CNT_W'(1);
         end
         if (awHs) awDone <= 1'b1;
         if (wHs)  wDone  <= 1'b1;
         if (rHs)  wbs_dat_o <= rdata;
         if (smHs) begin
            wbs_dat_o <= sm_tdata;
            lastSeen  <= sm_tlast;
         end
      end
   end

endmodule

// File: tb/tb_wb_axi_bridge.sv
// Directed bench for wb_axi_bridge: a transaction-level outcome model predicts ack/err,
// latency and read data from responder delays, while a monitor checks bus payloads each cycle.
module tb_wb_axi_bridge;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam int          TO   = 4;

   logic        clk, rst, cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, datIn, datOut;
   logic        ack, err;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [11:0] awaddr, araddr;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        ss_tvalid, ss_tready, ss_tlast, sm_tvalid, sm_tready, sm_tlast;
   logic [31:0] ss_tdata, sm_tdata;

   int testsRun = 0;
   int testsFailed = 0;

   // Responder configuration: cycles from valid/ready assertion to the answering signal
   int          awDelay = 0, wDelay = 0, bDelay = 0, arDelay = 0, rDelay = 0, ssDelay = 0, smDelay = 0;
   logic [1:0]  bRespV = 2'b00, rRespV = 2'b00;
   logic [31:0] rDataV = '0, smDataV = '0;
   logic        smLastV = 1'b0;

   // Outcome model state and per-transaction expectations
   logic [31:0] modelDat = '0;
   logic        modelLast = 1'b0;
   logic [31:0] expOff = '0, expDat = '0, expDatOut = '0;
   logic [3:0]  expSel = '0;
   logic        expTlast = 1'b0, chkEn = 1'b0;

   int   awHs, wHs, bHs, arHs, rHs, ssHs, smHs;
   int   arValidCyc, ssValidCyc, ssLastCyc, anyValidCyc, ackCnt, errCnt;
   logic [3:0] lastWstrb = '0;
   int   lastLat;
   logic lastAck, lastErr;

   wb_axi_bridge #(
      .BASE_ADDR(BASE), .ADDR_W(12), .STRM_OFF('h80), .TIMEOUT(TO)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(datIn),
      .wbs_ack_o(ack), .wbs_err_o(err), .wbs_dat_o(datOut),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
      .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic int maxOf(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Slave-side responders, driven on the falling edge from the delay configuration
   initial begin : responder
      int awCnt, wCnt, bCnt, arCnt, rCnt, ssCnt, smCnt;
      awCnt = 0; wCnt = 0; bCnt = 0; arCnt = 0; rCnt = 0; ssCnt = 0; smCnt = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
      rvalid = 0; rdata = 0; rresp = 0; ss_tready = 0; sm_tvalid = 0; sm_tdata = 0; sm_tlast = 0;
      forever begin
         @(negedge clk);
         if (awvalid) begin awready = (awCnt >= awDelay); awCnt++; end else begin awready = 0; awCnt = 0; end
         if (wvalid)  begin wready  = (wCnt >= wDelay);   wCnt++;  end else begin wready = 0;  wCnt = 0;  end
         if (arvalid) begin arready = (arCnt >= arDelay); arCnt++; end else begin arready = 0; arCnt = 0; end
         if (ss_tvalid) begin ss_tready = (ssCnt >= ssDelay); ssCnt++; end else begin ss_tready = 0; ssCnt = 0; end
         if (bready) begin bvalid = (bCnt >= bDelay); bresp = bRespV; bCnt++; end else begin bvalid = 0; bCnt = 0; end
         if (rready) begin
            rvalid = (rCnt >= rDelay); rdata = rDataV; rresp = rRespV; rCnt++;
         end else begin
            rvalid = 0; rCnt = 0;
         end
         if (sm_tready) begin
            sm_tvalid = (smCnt >= smDelay); sm_tdata = smDataV; sm_tlast = smLastV; smCnt++;
         end else begin
            sm_tvalid = 0; smCnt = 0;
         end
      end
   end

   // Per-cycle monitor: exclusivity of ack/err, payloads while valid, read data at completion
   initial begin : monitor
      forever begin
         @(negedge clk);
         #2;
         if (ack) ackCnt++;
         if (err) errCnt++;
         if (!rst) begin
            checkOutput("ack_err_exclusive", 32'(ack & err), 32'd0);
            if (awvalid & awready) awHs++;
            if (wvalid & wready) begin wHs++; lastWstrb = wstrb; end
            if (bready & bvalid) bHs++;
            if (arvalid) arValidCyc++;
            if (arvalid & arready) arHs++;
            if (rready & rvalid) rHs++;
            if (ss_tvalid) ssValidCyc++;
            if (ss_tvalid & ss_tlast) ssLastCyc++;
            if (ss_tvalid & ss_tready) ssHs++;
            if (sm_tready & sm_tvalid) smHs++;
            if (awvalid | wvalid | bready | arvalid | rready | ss_tvalid | sm_tready) anyValidCyc++;
            if (chkEn) begin
               if (awvalid) checkOutput("awaddr", 32'(awaddr), 32'(expOff[11:0]));
               if (arvalid) checkOutput("araddr", 32'(araddr), 32'(expOff[11:0]));
               if (wvalid) begin
                  checkOutput("wdata", wdata, expDat);
                  checkOutput("wstrb", 32'(wstrb), 32'(expSel));
               end
               if (ss_tvalid) begin
                  checkOutput("ss_tdata", ss_tdata, expDat);
                  checkOutput("ss_tlast", 32'(ss_tlast), 32'(expTlast));
               end
               if (ack | err) checkOutput("dat_o_at_completion", datOut, expDatOut);
            end
         end
      end
   end

   // One Wishbone access: predict its outcome, run it, then compare outcome and bus activity
   task automatic applyStimulus(input string name, input logic isWrite, input logic [31:0] off,
                                input logic [31:0] dat, input logic [3:0] selIn);
      logic inWin, isLite, isFlag, pAck, pErr, pTimeout, pLast;
      logic [31:0] pDat;
      logic [1:0] resp;
      int h, pLat;
      inWin = off < 32'h1000;
      isLite = off < 32'h80;
      isFlag = !isWrite && (off == 32'h88);
      pAck = 0; pErr = 0; pTimeout = 0; pDat = modelDat; pLast = modelLast; pLat = 1; h = 0;
      if (!inWin) begin
         pErr = 1;
      end else if (isFlag) begin
         pAck = 1; pDat = {31'b0, modelLast}; pLast = 0;
      end else begin
         if (isLite) h = isWrite ? maxOf(awDelay, wDelay) + 1 + bDelay : arDelay + 1 + rDelay;
         else        h = isWrite ? ssDelay : smDelay;
         if (h >= TO) begin
            pTimeout = 1; pErr = 1; pLat = TO + 2;
         end else begin
            pLat = h + 2;
            resp = isLite ? (isWrite ? bRespV : rRespV) : 2'b00;
            pErr = (resp != 2'b00);
            pAck = !pErr;
            if (!isWrite) pDat = isLite ? rDataV : smDataV;
            if (!isWrite && !isLite) pLast = smLastV;
         end
      end

      @(negedge clk);
      awHs = 0; wHs = 0; bHs = 0; arHs = 0; rHs = 0; ssHs = 0; smHs = 0;
      arValidCyc = 0; ssValidCyc = 0; ssLastCyc = 0; anyValidCyc = 0; ackCnt = 0; errCnt = 0;
      expOff = off; expDat = dat; expSel = selIn; expTlast = (off == 32'h84); expDatOut = pDat;
      chkEn = 1;
      cyc = 1; stb = 1; we = isWrite; adr = BASE + off; datIn = dat; sel = selIn;
      lastLat = 0; lastAck = 0; lastErr = 0;
      while (lastLat < 40 && !lastAck && !lastErr) begin
         @(posedge clk);
         #1;
         lastLat++;
         lastAck = ack;
         lastErr = err;
      end
      @(negedge clk);
      cyc = 0; stb = 0; we = 0;
      #3;
      chkEn = 0;

      checkOutput({name, "_ack"}, 32'(lastAck), 32'(pAck));
      checkOutput({name, "_err"}, 32'(lastErr), 32'(pErr));
      checkOutput({name, "_latency"}, 32'(lastLat), 32'(pLat));
      checkOutput({name, "_ack_pulses"}, 32'(ackCnt), pAck ? 32'd1 : 32'd0);
      checkOutput({name, "_err_pulses"}, 32'(errCnt), pErr ? 32'd1 : 32'd0);
      checkOutput({name, "_dat_o"}, datOut, pDat);
      if (!inWin || isFlag) begin
         checkOutput({name, "_no_axi_activity"}, 32'(anyValidCyc), 32'd0);
      end else if (pTimeout) begin
         checkOutput({name, "_timeout_wait_cycles"}, 32'(anyValidCyc), 32'(TO));
      end else if (isLite && isWrite) begin
         checkOutput({name, "_aw_handshakes"}, 32'(awHs), 32'd1);
         checkOutput({name, "_w_handshakes"}, 32'(wHs), 32'd1);
         checkOutput({name, "_b_handshakes"}, 32'(bHs), 32'd1);
      end else if (isLite) begin
         checkOutput({name, "_ar_handshakes"}, 32'(arHs), 32'd1);
         checkOutput({name, "_r_handshakes"}, 32'(rHs), 32'd1);
      end else if (isWrite) begin
         checkOutput({name, "_ss_handshakes"}, 32'(ssHs), 32'd1);
         checkOutput({name, "_ss_valid_cycles"}, 32'(ssValidCyc), 32'(ssDelay + 1));
      end else begin
         checkOutput({name, "_sm_handshakes"}, 32'(smHs), 32'd1);
      end
      modelDat = pDat;
      modelLast = pLast;
   endtask

   task automatic checkQuiet(input string name);
      checkOutput({name, "_controls"},
                  32'({ack, err, awvalid, wvalid, bready, arvalid, rready, ss_tvalid, ss_tlast, sm_tready}),
                  32'd0);
      checkOutput({name, "_dat_o"}, datOut, 32'd0);
   endtask

   // Reset while the bridge waits for the write response: no response may ever appear
   task automatic resetDuringLb();
      int waited;
      bDelay = 3;
      @(negedge clk);
      ackCnt = 0; errCnt = 0;
      cyc = 1; stb = 1; we = 1; adr = BASE + 32'h8; datIn = 32'h0000_00FF; sel = 4'hF;
      waited = 0;
      while (!bready && waited < 20) begin
         @(negedge clk);
         #2;
         waited++;
      end
      checkOutput("rst_mid_reached_lb", 32'(bready), 32'd1);
      rst = 1; cyc = 0; stb = 0; we = 0;
      @(posedge clk);
      #1;
      checkQuiet("rst_mid_in_reset");
      @(negedge clk);
      rst = 0;
      repeat (3) @(posedge clk);
      #1;
      checkQuiet("rst_mid_after_release");
      checkOutput("rst_mid_ack_pulses", 32'(ackCnt), 32'd0);
      checkOutput("rst_mid_err_pulses", 32'(errCnt), 32'd0);
      bDelay = 0;
      modelDat = '0;
      modelLast = 1'b0;
   endtask

   initial begin
      rst = 1; cyc = 0; stb = 0; we = 0; sel = '0; adr = '0; datIn = '0;
      repeat (2) @(posedge clk);
      #1;
      checkQuiet("reset_state");
      @(negedge clk);
      rst = 0;

      awDelay = 2;
      applyStimulus("lite_wr_slow_aw", 1, 32'h10, 32'hA5A5_0001, 4'b0011);
      checkOutput("lite_wr_slow_aw_wstrb_literal", 32'(lastWstrb), 32'h3);
      checkOutput("lite_wr_slow_aw_latency_literal", 32'(lastLat), 32'd5);
      awDelay = 0;

      applyStimulus("lite_wr_fast", 1, 32'h04, 32'h0BAD_CAFE, 4'hF);
      checkOutput("lite_wr_min_latency_literal", 32'(lastLat), 32'd3);

      rDataV = 32'h1234_5678; rRespV = 2'd2;
      applyStimulus("lite_rd_slverr", 0, 32'h20, 32'h0, 4'hF);
      checkOutput("lite_rd_slverr_dat_literal", datOut, 32'h1234_5678);
      checkOutput("lite_rd_slverr_err_literal", 32'(lastErr), 32'd1);
      rRespV = 2'd0;

      rDataV = 32'hCAFE_F00D;
      applyStimulus("lite_rd_fast", 0, 32'h30, 32'h0, 4'hF);
      checkOutput("lite_rd_min_latency_literal", 32'(lastLat), 32'd3);

      ssDelay = 3;
      applyStimulus("strm_wr_last", 1, 32'h84, 32'hDEAD_BEEF, 4'hF);
      checkOutput("strm_wr_last_tvalid_cycles_literal", 32'(ssValidCyc), 32'd4);
      checkOutput("strm_wr_last_tlast_cycles_literal", 32'(ssLastCyc), 32'd4);
      checkOutput("strm_wr_last_latency_literal", 32'(lastLat), 32'd5);
      ssDelay = 0;

      applyStimulus("strm_wr_plain", 1, 32'h80, 32'h0000_1111, 4'hF);
      checkOutput("strm_wr_min_latency_literal", 32'(lastLat), 32'd2);
      checkOutput("strm_wr_plain_tlast_literal", 32'(ssLastCyc), 32'd0);

      smDataV = 32'd7; smLastV = 1;
      applyStimulus("strm_rd_last", 0, 32'h90, 32'h0, 4'hF);
      checkOutput("strm_rd_dat_literal", datOut, 32'd7);
      checkOutput("strm_rd_min_latency_literal", 32'(lastLat), 32'd2);

      applyStimulus("last_flag_rd1", 0, 32'h88, 32'h0, 4'hF);
      checkOutput("last_flag_set_literal", datOut, 32'd1);
      applyStimulus("last_flag_rd2", 0, 32'h88, 32'h0, 4'hF);
      checkOutput("last_flag_cleared_literal", datOut, 32'd0);

      arDelay = 100;
      applyStimulus("lite_rd_timeout", 0, 32'h40, 32'h0, 4'hF);
      checkOutput("timeout_arvalid_cycles_literal", 32'(arValidCyc), 32'd4);
      checkOutput("timeout_err_literal", 32'(lastErr), 32'd1);
      arDelay = 0;

      rDataV = 32'h55AA_55AA;
      applyStimulus("lite_rd_after_timeout", 0, 32'h44, 32'h0, 4'hF);
      checkOutput("after_timeout_dat_literal", datOut, 32'h55AA_55AA);

      applyStimulus("out_of_window_wr", 1, 32'h1000, 32'h1, 4'hF);
      checkOutput("out_of_window_latency_literal", 32'(lastLat), 32'd1);
      applyStimulus("below_base_rd", 0, 32'hFFFF_FFFC, 32'h0, 4'hF);

      bRespV = 2'd2;
      applyStimulus("lite_wr_bresp_err", 1, 32'h08, 32'h7777_0000, 4'b1100);
      bRespV = 2'd0;

      smDataV = 32'h11; smLastV = 1; smDelay = 2;
      applyStimulus("strm_rd_slow", 0, 32'h94, 32'h0, 4'hF);
      smDelay = 0; smLastV = 0;

      resetDuringLb();

      applyStimulus("flag_after_reset", 0, 32'h88, 32'h0, 4'hF);
      applyStimulus("lite_wr_after_reset", 1, 32'h0C, 32'h0102_0304, 4'b0101);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
